// File: rtl/shift_counter_pkg.sv
// Shared constants and helpers for the Johnson/ring shift counter family.
package shift_counter_pkg;

  localparam int MODE_JOHNSON = 0;
  localparam int MODE_RING    = 1;

  function automatic int idx_width(input int width);
    return $clog2(2 * width);
  endfunction

  // Ring counters start with a single token in bit 0; Johnson counters start empty.
  function automatic logic [31:0] reset_state(input int mode, input int width);
    logic [31:0] r;
    r = '0;
    if (mode == MODE_RING && width > 0) r[0] = 1'b1;
    return r;
  endfunction

endpackage

// File: rtl/shift_counter_decode.sv
// Combinational decode of a counter state into its up-sequence index and a legality flag.
module shift_counter_decode
  import shift_counter_pkg::*;
#(
  parameter int WIDTH = 4,
  parameter int MODE  = MODE_JOHNSON,
  parameter int IDX_W = idx_width(WIDTH)
) (
  input  logic [WIDTH-1:0] q,
  output logic [IDX_W-1:0] state_index,
  output logic             illegal
);

  always_comb begin
    int pop;
    int trans;
    int pos;
    pop   = 0;
    trans = 0;
    pos   = 0;
    for (int i = 0; i < WIDTH; i++) begin
      pop += int'(q[i]);
      if (q[i]) pos = i;
    end
    for (int i = 0; i < WIDTH - 1; i++) begin
      if (q[i] != q[i+1]) trans++;
    end

    illegal     = 1'b0;
    state_index = '0;
    if (MODE == MODE_RING) begin
      illegal     = (pop != 1);
      state_index = IDX_W'(pos);
    end else begin
      // A Johnson word is a single run of ones anchored at one end: at most one edge.
      illegal = (trans > 1);
      if (q == '0)     state_index = '0;
      else if (q[0])   state_index = IDX_W'(pop);
      else             state_index = IDX_W'(2 * WIDTH - pop);
    end
    if (illegal) state_index = '0;
  end

endmodule

// File: rtl/shift_counter_gen.sv
// Parametrised Johnson/ring shift counter with load, direction, self-correction and wrap pulse.
module shift_counter_gen
  import shift_counter_pkg::*;
#(
  parameter int WIDTH = 4,
  parameter int MODE  = MODE_JOHNSON,
  parameter int IDX_W = idx_width(WIDTH)
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             enable,
  input  logic             dir,
  input  logic             load,
  input  logic [WIDTH-1:0] load_value,
  output logic [WIDTH-1:0] q,
  output logic [IDX_W-1:0] state_index,
  output logic             illegal,
  output logic             wrap
);

  localparam logic [31:0]      RST_FULL = reset_state(MODE, WIDTH);
  localparam logic [WIDTH-1:0] RST_Q    = RST_FULL[WIDTH-1:0];
  localparam int               LAST_IDX = (MODE == MODE_RING) ? WIDTH - 1 : 2 * WIDTH - 1;

  logic [WIDTH-1:0] q_q, q_d;
  logic             wrap_q, wrap_d;
  logic [WIDTH-1:0] shift_c;
  logic [IDX_W-1:0] nxt_index;
  logic             nxt_illegal;
  logic [IDX_W-1:0] term_idx;

  shift_counter_decode #(.WIDTH(WIDTH), .MODE(MODE), .IDX_W(IDX_W)) u_dec_cur (
    .q           (q_q),
    .state_index (state_index),
    .illegal     (illegal)
  );

  // Decoding the shifted value tells us, one edge early, whether the shift lands on a terminal state.
  shift_counter_decode #(.WIDTH(WIDTH), .MODE(MODE), .IDX_W(IDX_W)) u_dec_nxt (
    .q           (shift_c),
    .state_index (nxt_index),
    .illegal     (nxt_illegal)
  );

  always_comb begin
    shift_c = q_q;
    if (MODE == MODE_RING)
      shift_c = dir ? {q_q[0], q_q[WIDTH-1:1]} : {q_q[WIDTH-2:0], q_q[WIDTH-1]};
    else
      shift_c = dir ? {~q_q[0], q_q[WIDTH-1:1]} : {q_q[WIDTH-2:0], ~q_q[WIDTH-1]};
  end

  always_comb begin
    term_idx = dir ? IDX_W'(LAST_IDX) : '0;
    q_d      = q_q;
    wrap_d   = 1'b0;
    if (load) begin
      q_d = load_value;
    end else if (illegal) begin
      q_d = RST_Q;
    end else if (enable) begin
      q_d    = shift_c;
      wrap_d = !nxt_illegal && (nxt_index == term_idx);
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      q_q    <= RST_Q;
      wrap_q <= 1'b0;
    end else begin
      q_q    <= q_d;
      wrap_q <= wrap_d;
    end
  end

  assign q    = q_q;
  assign wrap = wrap_q;

endmodule

// File: tb/tb_shift_counter_gen.sv
// Scoreboard bench: four counter instances driven by directed vectors with hand-computed results.
module tb_shift_counter_gen;

  logic        clock = 1'b0;
  logic [3:0]  rst   = 4'b1111;
  logic        en    = 1'b0;
  logic        dr    = 1'b0;
  logic        ld    = 1'b0;
  logic [31:0] lv    = '0;

  logic [3:0] q0, q1;
  logic [1:0] q2;
  logic [7:0] q3;
  logic [2:0] i0;
  logic [1:0] i1;
  logic [1:0] i2;
  logic [3:0] i3;
  logic [3:0] ill, wr;

  always #5 clock = ~clock;

  shift_counter_gen #(.WIDTH(4), .MODE(0)) dut_j4 (
    .clock(clock), .reset(rst[0]), .enable(en), .dir(dr), .load(ld), .load_value(lv[3:0]),
    .q(q0), .state_index(i0), .illegal(ill[0]), .wrap(wr[0]));
  shift_counter_gen #(.WIDTH(4), .MODE(1)) dut_r4 (
    .clock(clock), .reset(rst[1]), .enable(en), .dir(dr), .load(ld), .load_value(lv[3:0]),
    .q(q1), .state_index(i1), .illegal(ill[1]), .wrap(wr[1]));
  shift_counter_gen #(.WIDTH(2), .MODE(0)) dut_j2 (
    .clock(clock), .reset(rst[2]), .enable(en), .dir(dr), .load(ld), .load_value(lv[1:0]),
    .q(q2), .state_index(i2), .illegal(ill[2]), .wrap(wr[2]));
  shift_counter_gen #(.WIDTH(8), .MODE(0)) dut_j8 (
    .clock(clock), .reset(rst[3]), .enable(en), .dir(dr), .load(ld), .load_value(lv[7:0]),
    .q(q3), .state_index(i3), .illegal(ill[3]), .wrap(wr[3]));

  typedef struct {
    int          sel;
    int          step;
    logic [31:0] q;
    logic [7:0]  idx;
    logic        ill;
    logic        wrap;
  } exp_t;

  exp_t sb[$];
  int   n_checks = 0;
  int   n_fail   = 0;
  int   step_no  = 0;
  int   wraps8   = 0;

  exp_t        e;
  logic [31:0] aq;
  logic [7:0]  ai;
  logic        ail, aw;

  // Monitor: compares every cycle for which the stimulus side queued an expectation.
  always @(negedge clock) begin
    if (sb.size() > 0) begin
      e = sb.pop_front();
      case (e.sel)
        0:       begin aq = 32'(q0); ai = 8'(i0); ail = ill[0]; aw = wr[0]; end
        1:       begin aq = 32'(q1); ai = 8'(i1); ail = ill[1]; aw = wr[1]; end
        2:       begin aq = 32'(q2); ai = 8'(i2); ail = ill[2]; aw = wr[2]; end
        default: begin aq = 32'(q3); ai = 8'(i3); ail = ill[3]; aw = wr[3]; end
      endcase
      if (e.sel == 3 && aw === 1'b1) wraps8++;
      n_checks++;
      if ({aq, ai, ail, aw} !== {e.q, e.idx, e.ill, e.wrap}) begin
        n_fail++;
        $display("FAIL inst%0d step%0d: got q=%h idx=%0d illegal=%b wrap=%b, want q=%h idx=%0d illegal=%b wrap=%b",
                 e.sel, e.step, aq, ai, ail, aw, e.q, e.idx, e.ill, e.wrap);
      end
    end
  end

  task automatic cyc(input int sel, input logic r, input logic e_i, input logic d_i,
                     input logic l_i, input logic [31:0] lv_i,
                     input logic [31:0] eq, input int eidx, input logic eill, input logic ewrap);
    exp_t x;
    rst       = 4'b1111;
    rst[sel]  = r;
    en        = e_i;
    dr        = d_i;
    ld        = l_i;
    lv        = lv_i;
    @(posedge clock);
    #1;
    step_no++;
    x.sel  = sel;
    x.step = step_no;
    x.q    = eq;
    x.idx  = 8'(eidx);
    x.ill  = eill;
    x.wrap = ewrap;
    sb.push_back(x);
  endtask

  initial begin
    logic [31:0] v;
    int          budget;
    #2;
    // Johnson WIDTH=4: reset then full up cycle
    cyc(0, 1, 0, 0, 0, 0, 32'h0, 0, 0, 0);
    cyc(0, 0, 1, 0, 0, 0, 32'h1, 1, 0, 0);
    cyc(0, 0, 1, 0, 0, 0, 32'h3, 2, 0, 0);
    cyc(0, 0, 1, 0, 0, 0, 32'h7, 3, 0, 0);
    cyc(0, 0, 1, 0, 0, 0, 32'hF, 4, 0, 0);
    cyc(0, 0, 1, 0, 0, 0, 32'hE, 5, 0, 0);
    cyc(0, 0, 1, 0, 0, 0, 32'hC, 6, 0, 0);
    cyc(0, 0, 1, 0, 0, 0, 32'h8, 7, 0, 0);
    cyc(0, 0, 1, 0, 0, 0, 32'h0, 0, 0, 1);
    // Down cycle from 0000
    cyc(0, 0, 1, 1, 0, 0, 32'h8, 7, 0, 1);
    cyc(0, 0, 1, 1, 0, 0, 32'hC, 6, 0, 0);
    cyc(0, 0, 1, 1, 0, 0, 32'hE, 5, 0, 0);
    cyc(0, 0, 1, 1, 0, 0, 32'hF, 4, 0, 0);
    cyc(0, 0, 1, 1, 0, 0, 32'h7, 3, 0, 0);
    cyc(0, 0, 1, 1, 0, 0, 32'h3, 2, 0, 0);
    cyc(0, 0, 1, 1, 0, 0, 32'h1, 1, 0, 0);
    cyc(0, 0, 1, 1, 0, 0, 32'h0, 0, 0, 0);
    // Up to 1110, then reverse direction
    cyc(0, 0, 1, 0, 0, 0, 32'h1, 1, 0, 0);
    cyc(0, 0, 1, 0, 0, 0, 32'h3, 2, 0, 0);
    cyc(0, 0, 1, 0, 0, 0, 32'h7, 3, 0, 0);
    cyc(0, 0, 1, 0, 0, 0, 32'hF, 4, 0, 0);
    cyc(0, 0, 1, 0, 0, 0, 32'hE, 5, 0, 0);
    cyc(0, 0, 1, 1, 0, 0, 32'hF, 4, 0, 0);
    cyc(0, 0, 0, 1, 0, 0, 32'hF, 4, 0, 0);
    // Illegal load and self-correction, with and without enable
    cyc(0, 0, 0, 0, 1, 32'h5, 32'h5, 0, 1, 0);
    cyc(0, 0, 0, 0, 0, 0,     32'h0, 0, 0, 0);
    cyc(0, 0, 0, 0, 1, 32'h9, 32'h9, 0, 1, 0);
    cyc(0, 0, 1, 0, 0, 0,     32'h0, 0, 0, 0);
    cyc(0, 0, 0, 0, 1, 32'h5, 32'h5, 0, 1, 0);
    cyc(0, 0, 1, 0, 1, 32'h5, 32'h5, 0, 1, 0);
    // Priority: load beats enable, hold, load of a terminal value raises no wrap
    cyc(0, 0, 1, 0, 1, 32'h3, 32'h3, 2, 0, 0);
    cyc(0, 0, 0, 0, 0, 0,     32'h3, 2, 0, 0);
    cyc(0, 0, 0, 1, 0, 0,     32'h3, 2, 0, 0);
    cyc(0, 0, 0, 0, 0, 0,     32'h3, 2, 0, 0);
    cyc(0, 0, 1, 0, 1, 32'h8, 32'h8, 7, 0, 0);
    cyc(0, 0, 1, 0, 1, 32'h0, 32'h0, 0, 0, 0);
    cyc(0, 0, 1, 1, 0, 0,     32'h8, 7, 0, 1);
    cyc(0, 1, 1, 0, 1, 32'h7, 32'h0, 0, 0, 0);

    // Ring WIDTH=4
    cyc(1, 1, 0, 0, 0, 0, 32'h1, 0, 0, 0);
    cyc(1, 0, 1, 0, 0, 0, 32'h2, 1, 0, 0);
    cyc(1, 0, 1, 0, 0, 0, 32'h4, 2, 0, 0);
    cyc(1, 0, 1, 0, 0, 0, 32'h8, 3, 0, 0);
    cyc(1, 0, 1, 0, 0, 0, 32'h1, 0, 0, 1);
    cyc(1, 0, 1, 1, 0, 0, 32'h8, 3, 0, 1);
    cyc(1, 0, 1, 1, 0, 0, 32'h4, 2, 0, 0);
    cyc(1, 0, 0, 0, 1, 32'h0, 32'h0, 0, 1, 0);
    cyc(1, 0, 1, 0, 0, 0,     32'h1, 0, 0, 0);
    cyc(1, 0, 0, 0, 1, 32'h6, 32'h6, 0, 1, 0);
    cyc(1, 0, 0, 0, 0, 0,     32'h1, 0, 0, 0);

    // Johnson WIDTH=2: two full periods of 4
    cyc(2, 1, 0, 0, 0, 0, 32'h0, 0, 0, 0);
    for (int p = 0; p < 2; p++) begin
      cyc(2, 0, 1, 0, 0, 0, 32'h1, 1, 0, 0);
      cyc(2, 0, 1, 0, 0, 0, 32'h3, 2, 0, 0);
      cyc(2, 0, 1, 0, 0, 0, 32'h2, 3, 0, 0);
      cyc(2, 0, 1, 0, 0, 0, 32'h0, 0, 0, 1);
    end

    // Johnson WIDTH=8: two full periods of 16 (fill with ones, then drain from the LSB)
    cyc(3, 1, 0, 0, 0, 0, 32'h0, 0, 0, 0);
    for (int p = 0; p < 2; p++) begin
      for (int k = 1; k <= 16; k++) begin
        if (k <= 8) v = (32'h1 << k) - 32'h1;
        else        v = (32'hFF << (k - 8)) & 32'hFF;
        cyc(3, 0, 1, 0, 0, 0, v, k % 16, 0, (k == 16));
      end
    end

    budget = 0;
    while (sb.size() > 0 && budget < 20) begin
      @(posedge clock);
      budget++;
    end
    #1;
    n_checks++;
    if (sb.size() != 0) begin
      n_fail++;
      $display("FAIL drain: got %0d pending entries, want 0", sb.size());
    end
    n_checks++;
    if (wraps8 != 2) begin
      n_fail++;
      $display("FAIL wrap_count_w8: got %0d wraps, want 2", wraps8);
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout, want completion");
    $fatal(1, "watchdog expired");
  end

endmodule
